bt_uart_tx: RTL and testbench

Transmit side of the cart's Bluetooth serial link. Accepts bytes from the control logic through a write strobe, buffers them in a small FIFO, and serialises each one onto `TxD` as 8N1 UART (LSB first) at a fixed baud rate. It drives the HC-05 module's RX pin and sends status and telemetry bytes (mode, distance, ack codes) back to the phone. It is the counterpart of the existing Bluetooth receiver.

---
 rtl/bt_pkg.sv | 37 +++
 rtl/bt_tx_fifo.sv | 67 ++++++
 rtl/bt_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_bt_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bt_pkg
//  Description : Shared definitions for the Bluetooth serial link (HC-05).
//                Holds the transmitter FSM encoding, the default clock/baud
//                pair used by both the receiver and the transmitter, and the
//                byte codes of the status/telemetry messages sent to the phone.
//  Revision    : 1.0  initial release
// ============================================================================
package bt_pkg;

  // Serialiser states. ST_PARITY is only reachable in 8E1 builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Receiver and transmitter must agree on these.
  localparam int BT_CLK_HZ = 100_000_000;
  localparam int BT_BAUD   = 9600;

  // Message byte codes sent back to the phone.
  localparam logic [7:0] BT_CODE_ACK  = 8'h06;
  localparam logic [7:0] BT_CODE_NAK  = 8'h15;
  localparam logic [7:0] BT_CODE_MODE = 8'h4D;
  localparam logic [7:0] BT_CODE_DIST = 8'h44;

  // Even parity bit: makes the count of 1s over data+parity even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bt_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bt_tx_fifo
//  Description : Synchronous byte FIFO, depth 2^AW. Registered read data,
//                read-before-write when push and pop hit the same cycle.
//                Pushes while full and pops while empty are ignored.
//  Ports       : clk, rst (async, active-high)
//                push, push_data[7:0]  - write side
//                pop,  pop_data[7:0]   - read side (valid the cycle after pop)
//                count[AW:0], full, empty - occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module bt_tx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // Occupancy flags come from the registered count only.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        // Non-blocking read sees the old contents: read-before-write.
        pop_data <= mem[rptr];
        rptr     <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bt_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bt_uart_tx
//  Description : Bluetooth UART transmitter. Queues bytes in a FIFO and sends
//                each one LSB first at CLK_HZ/BAUD clocks per bit.
//                Build option BT_UART_TX_PARITY_EN: when defined, frames are
//                8E1 (11 bits); otherwise 8N1 (10 bits, HC-05 default).
//  Ports       : clk, rst (async, active-high)
//                wr_data[7:0], wr_en      - byte write strobe
//                full, fifo_count, overflow - queue status (overflow sticky)
//                busy                     - serialiser not idle
//                TxD                      - serial line, idle high
//  Revision    : 1.0  initial release
// ============================================================================
module bt_uart_tx
  import bt_pkg::*;
#(
  parameter int CLK_HZ  = BT_CLK_HZ,
  parameter int BAUD    = BT_BAUD,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         wr_data,
  input  logic               wr_en,
  output logic               full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               busy,
  output logic               overflow,
  output logic               TxD
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("bt_uart_tx: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_last;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             txd_nxt;
  logic             pop;
  logic             empty;
  logic [7:0]       pop_data;
`ifdef BT_UART_TX_PARITY_EN
  logic             par_bit;
`endif

  bt_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign baud_last = (baud_cnt == CNT_LAST);
  assign busy      = (state != ST_IDLE);

  // TxD is registered from the value the line must hold in the *next* state,
  // so the start bit appears the cycle after the pop with no glitching.
  always_comb begin
    state_nxt = state;
    txd_nxt   = 1'b1;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_START;
          txd_nxt   = 1'b0;
        end
      end
      ST_START: begin
        txd_nxt = 1'b0;
        if (baud_last) begin
          // Popped byte is in pop_data by now; shreg is loaded on this edge.
          state_nxt = ST_DATA;
          txd_nxt   = pop_data[0];
        end
      end
      ST_DATA: begin
        txd_nxt = shreg[0];
        if (baud_last) begin
          if (bit_cnt == 3'd7) begin
`ifdef BT_UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
            txd_nxt   = par_bit;
`else
            state_nxt = ST_STOP;
            txd_nxt   = 1'b1;
`endif
          end else begin
            txd_nxt = shreg[1];
          end
        end
      end
`ifdef BT_UART_TX_PARITY_EN
      ST_PARITY: begin
        txd_nxt = par_bit;
        if (baud_last) begin
          state_nxt = ST_STOP;
          txd_nxt   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_last) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      TxD   <= 1'b1;
    end else begin
      state <= state_nxt;
      TxD   <= txd_nxt;
    end
  end

  // Baud counter restarts on every state change, so each bit is exactly DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      overflow <= 1'b0;
`ifdef BT_UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (wr_en && full) overflow <= 1'b1;

      if (state == ST_IDLE || state_nxt != state || baud_last)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      if (state == ST_START && baud_last) begin
        shreg   <= pop_data;
        bit_cnt <= '0;
`ifdef BT_UART_TX_PARITY_EN
        par_bit <= even_parity(pop_data);
`endif
      end else if (state == ST_DATA && baud_last) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bt_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bt_uart_tx
//  Description : Directed self-checking bench for bt_uart_tx at DIV = 10
//                (CLK_HZ = 1000, BAUD = 100). Follows 8E1 framing when
//                BT_UART_TX_PARITY_EN is defined, 8N1 otherwise.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bt_uart_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = 10;
`ifdef BT_UART_TX_PARITY_EN
  localparam int NB = 11;
  // 0x6F LSB first: start 0, data 1111_0110, parity 0, stop 1 (index 0 = start)
  localparam logic [NB-1:0] F6F = 11'b10011011110;
`else
  localparam int NB = 10;
  localparam logic [NB-1:0] F6F = 10'b1011011110;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full;
  logic [4:0] fifo_count;
  logic       busy;
  logic       overflow;
  logic       TxD;

  int n_cmp = 0;
  int n_err = 0;

  bt_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow),
    .TxD        (TxD)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed run still active, required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit, samples every bit mid-period, and leaves the caller
  // on the idle cycle that follows the stop bit.
  task automatic rx_frame(input int max_wait, output logic [7:0] b,
                          output logic p, output int waited, output bit ok);
    b = 8'h00; p = 1'b0; waited = 0; ok = 1'b0;
    while (waited < max_wait) begin
      step();
      waited++;
      if (TxD === 1'b0) break;
    end
    if (TxD !== 1'b0) begin
      check("rx_start_seen", TxD, 0);
      return;
    end
    ok = 1'b1;
    repeat (5) step();
    check("rx_start_bit", TxD, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) step();
      b[i] = TxD;
    end
`ifdef BT_UART_TX_PARITY_EN
    repeat (DIV) step();
    p = TxD;
`endif
    repeat (DIV) step();
    check("rx_stop_bit", TxD, 1);
    repeat (5) step();
    check("rx_idle_gap", TxD, 1);
  endtask

  initial begin
    logic [7:0] b;
    logic       p;
    int         waited;
    bit         ok;
    bit         saw_low;
    int         peak;
    logic [7:0] tab [18];

    // ---------------- reset state
    repeat (3) step();
    check("rst_txd", TxD, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    step();

    // ---------------- test 1: single byte 0x6F, cycle-exact
    wr_data = 8'h6F; wr_en = 1'b1;      // cycle 0
    step();
    wr_en = 1'b0;                        // cycle 1
    check("t1_count_c1", fifo_count, 1);
    check("t1_txd_c1", TxD, 1);
    check("t1_busy_c1", busy, 0);
    step();                              // cycle 2
    check("t1_count_c2", fifo_count, 0);
    for (int c = 0; c < FRAME; c++) begin
      check("t1_txd", TxD, F6F[c / DIV]);
      check("t1_busy", busy, 1);
      step();
    end
    check("t1_busy_end", busy, 0);       // cycle 2+FRAME
    check("t1_txd_end", TxD, 1);
    repeat (5) step();

    // ---------------- test 2: three back-to-back bytes
    tab[0] = 8'h00; tab[1] = 8'hFF; tab[2] = 8'hA5;
    peak = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          wr_data = tab[i]; wr_en = 1'b1;
          step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 150; i++) begin
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
          step();
        end
      end
      begin
        for (int i = 0; i < 3; i++) begin
          rx_frame(200, b, p, waited, ok);
          if (ok) begin
            check("t2_byte", b, tab[i]);
            check("t2_wait", waited, (i == 0) ? 2 : 1);
          end
        end
        check("t2_busy_after", busy, 0);
        check("t2_count_after", fifo_count, 0);
      end
    join
    check("t2_peak", peak, 2);
    repeat (5) step();

    // ---------------- test 3: 17 writes fill the FIFO, 18th dropped
    for (int i = 0; i < 18; i++) tab[i] = 8'(i * 37 + 5);
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          wr_data = tab[i]; wr_en = 1'b1;
          if (i == 16) check("t3_full_before", full, 0);
          if (i == 17) begin
            check("t3_full", full, 1);
            check("t3_count_full", fifo_count, 16);
            check("t3_ovf_before", overflow, 0);
          end
          step();
        end
        wr_en = 1'b0;
        check("t3_ovf_set", overflow, 1);
        check("t3_count_hold", fifo_count, 16);
      end
      begin
        for (int i = 0; i < 17; i++) begin
          rx_frame(200, b, p, waited, ok);
          if (ok) check("t3_byte", b, tab[i]);
        end
        saw_low = 1'b0;
        for (int i = 0; i < 300; i++) begin
          if (TxD !== 1'b1) saw_low = 1'b1;
          step();
        end
        check("t3_no_extra_frame", saw_low, 0);
        check("t3_ovf_sticky", overflow, 1);
      end
    join

    // ---------------- test 4: reset in the middle of 0x55 data bits
    wr_data = 8'h55; wr_en = 1'b1;       // cycle 0
    step();
    wr_data = 8'h33;                     // cycle 1, stays queued
    step();
    wr_en = 1'b0;                        // cycle 2
    repeat (43) step();                  // cycle 45: data bit 3 (0)
    check("t4_txd_low", TxD, 0);
    check("t4_count_pre", fifo_count, 1);
    check("t4_ovf_pre", overflow, 1);
    rst = 1'b1;
    #1;
    check("t4_txd_async", TxD, 1);
    check("t4_count_rst", fifo_count, 0);
    check("t4_busy_rst", busy, 0);
    check("t4_ovf_rst", overflow, 0);
    step();
    rst = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (TxD !== 1'b1) saw_low = 1'b1;
      step();
    end
    check("t4_no_frame", saw_low, 0);

`ifdef BT_UART_TX_PARITY_EN
    // ---------------- test 5: parity bits for 0x6F and 0x07
    fork
      begin
        wr_data = 8'h6F; wr_en = 1'b1;
        step();
        wr_data = 8'h07;
        step();
        wr_en = 1'b0;
      end
      begin
        rx_frame(200, b, p, waited, ok);
        if (ok) begin
          check("t5_byte0", b, 8'h6F);
          check("t5_par0", p, 0);
        end
        rx_frame(200, b, p, waited, ok);
        if (ok) begin
          check("t5_byte1", b, 8'h07);
          check("t5_par1", p, 1);
          check("t5_wait1", waited, 1);
        end
      end
    join
    repeat (5) step();
`endif

    // ---------------- test 6: write while full coincides with a pop
    for (int i = 0; i < 17; i++) begin   // cycles 0..16
      wr_data = 8'(i + 8'h40); wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0;                        // cycle 17
    repeat (FRAME - 16) step();          // cycle 1+FRAME
    check("t6_busy_pre", busy, 1);
    check("t6_full_pre", full, 1);
    check("t6_ovf_pre", overflow, 0);
    step();                              // cycle 2+FRAME: idle, pop
    check("t6_idle", busy, 0);
    check("t6_full_at_pop", full, 1);
    wr_data = 8'hEE; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("t6_ovf", overflow, 1);
    check("t6_count", fifo_count, 15);
    check("t6_busy_post", busy, 1);
    check("t6_txd_post", TxD, 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
